// File: rtl/alu_ops.sv
// Shared ALU operation codes, WISC opcodes and execute-stage types.
package alu_ops;

    typedef enum logic [3:0] {
        OP_RLL = 4'b0000,
        OP_SLL = 4'b0001,
        OP_RRL = 4'b0010,
        OP_SRL = 4'b0011,
        OP_ADD = 4'b0100,
        OP_AND = 4'b0101,
        OP_OR  = 4'b0110,
        OP_XOR = 4'b0111,
        OP_BTR = 4'b1000,
        OP_RTB = 4'b1001,
        OP_RTA = 4'b1010
    } operT;

    typedef enum logic [2:0] {
        SET_NONE,
        SET_EQ,
        SET_LT,
        SET_LE,
        SET_CO
    } setKindT;

    typedef enum logic {
        P0,
        P1
    } phaseT;

    localparam logic [4:0] OPC_ADDI  = 5'b01000;
    localparam logic [4:0] OPC_SUBI  = 5'b01001;
    localparam logic [4:0] OPC_XORI  = 5'b01010;
    localparam logic [4:0] OPC_ANDNI = 5'b01011;
    localparam logic [4:0] OPC_SLBI  = 5'b10010;
    localparam logic [4:0] OPC_LBI   = 5'b11000;
    localparam logic [4:0] OPC_BTR   = 5'b11001;
    localparam logic [4:0] OPC_SHIFT = 5'b11010;
    localparam logic [4:0] OPC_ARITH = 5'b11011;
    localparam logic [4:0] OPC_SEQ   = 5'b11100;
    localparam logic [4:0] OPC_SLT   = 5'b11101;
    localparam logic [4:0] OPC_SLE   = 5'b11110;
    localparam logic [4:0] OPC_SCO   = 5'b11111;

    // Shift family order is ROL, SLL, ROR, SRL for both register and immediate forms.
    function automatic operT shiftOper(input logic [1:0] sel);
        case (sel)
            2'b00:   return OP_RLL;
            2'b01:   return OP_SLL;
            2'b10:   return OP_RRL;
            default: return OP_SRL;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// 16-bit ALU: optional operand inversion, adder with carry-in, shifts/rotates, logic ops and flags.
module alu
    import alu_ops::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    input  logic        invA,
    input  logic        invB,
    input  operT        oper,
    output logic [15:0] result,
    output logic        zf,
    output logic        sf,
    output logic        of,
    output logic        cf
);

    logic [15:0] opA;
    logic [15:0] opB;
    logic [16:0] sum;
    logic [3:0]  shamt;
    logic [15:0] bitRev;

    assign opA   = invA ? ~a : a;
    assign opB   = invB ? ~b : b;
    assign sum   = {1'b0, opA} + {1'b0, opB} + {16'b0, cin};
    assign shamt = opB[3:0];

    always_comb begin
        bitRev = '0;
        for (int i = 0; i < 16; i++) begin
            bitRev[i] = opA[15 - i];
        end
    end

    always_comb begin
        result = '0;
        case (oper)
            OP_RLL:  result = (opA << shamt) | (opA >> (5'd16 - {1'b0, shamt}));
            OP_SLL:  result = opA << shamt;
            OP_RRL:  result = (opA >> shamt) | (opA << (5'd16 - {1'b0, shamt}));
            OP_SRL:  result = opA >> shamt;
            OP_ADD:  result = sum[15:0];
            OP_AND:  result = opA & opB;
            OP_OR:   result = opA | opB;
            OP_XOR:  result = opA ^ opB;
            OP_BTR:  result = bitRev;
            OP_RTB:  result = opB;
            OP_RTA:  result = opA;
            default: result = '0;
        endcase
    end

    // Overflow is signed-add overflow on the already-inverted operands.
    assign zf = (result == 16'h0000);
    assign sf = result[15];
    assign cf = sum[16];
    assign of = (opA[15] == opB[15]) && (sum[15] != opA[15]);

endmodule

// File: rtl/alu_decode.sv
// Combinational WISC decode into ALU controls, immediate, set-kind and two-phase marker.
module alu_decode
    import alu_ops::*;
(
    input  logic [15:0] instr,
    output operT        oper,
    output logic        invA,
    output logic        invB,
    output logic        cin,
    output logic        bSelImm,
    output logic [15:0] imm,
    output setKindT     setKind,
    output logic        twoPhase,
    output logic        illegal
);

    logic [4:0] opcode;
    logic [1:0] fn;
    logic       unusedFields;

    assign opcode       = instr[15:11];
    assign fn           = instr[1:0];
    assign unusedFields = ^instr[10:8];

    always_comb begin
        oper     = OP_ADD;
        invA     = 1'b0;
        invB     = 1'b0;
        cin      = 1'b0;
        bSelImm  = 1'b0;
        imm      = '0;
        setKind  = SET_NONE;
        twoPhase = 1'b0;
        illegal  = 1'b0;
        casez (opcode)
            OPC_ARITH: begin
                case (fn)
                    2'b00:   oper = OP_ADD;
                    2'b01:   begin oper = OP_ADD; invA = 1'b1; cin = 1'b1; end
                    2'b10:   oper = OP_XOR;
                    default: begin oper = OP_AND; invB = 1'b1; end
                endcase
            end
            OPC_ADDI: begin
                bSelImm = 1'b1;
                imm     = {{11{instr[4]}}, instr[4:0]};
            end
            OPC_SUBI: begin
                invA    = 1'b1;
                cin     = 1'b1;
                bSelImm = 1'b1;
                imm     = {{11{instr[4]}}, instr[4:0]};
            end
            OPC_XORI: begin
                oper    = OP_XOR;
                bSelImm = 1'b1;
                imm     = {11'b0, instr[4:0]};
            end
            OPC_ANDNI: begin
                oper    = OP_AND;
                invB    = 1'b1;
                bSelImm = 1'b1;
                imm     = {11'b0, instr[4:0]};
            end
            OPC_SHIFT: oper = shiftOper(fn);
            5'b101??: begin
                oper    = shiftOper(opcode[1:0]);
                bSelImm = 1'b1;
                imm     = {11'b0, instr[4:0]};
            end
            OPC_BTR: oper = OP_BTR;
            OPC_LBI: begin
                oper    = OP_RTB;
                bSelImm = 1'b1;
                imm     = {{8{instr[7]}}, instr[7:0]};
            end
            // Only the first SLBI phase is described here; the top substitutes the OR phase.
            OPC_SLBI: begin
                oper     = OP_SLL;
                bSelImm  = 1'b1;
                imm      = 16'd8;
                twoPhase = 1'b1;
            end
            OPC_SEQ: begin invB = 1'b1; cin = 1'b1; setKind = SET_EQ; end
            OPC_SLT: begin invB = 1'b1; cin = 1'b1; setKind = SET_LT; end
            OPC_SLE: begin invB = 1'b1; cin = 1'b1; setKind = SET_LE; end
            OPC_SCO: setKind = SET_CO;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: S1 holds the decoded instruction feeding the ALU, S2 holds the result.
module alu_exec_ctrl
    import alu_ops::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_instr,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_rt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_illegal
);

    phaseT            phase;
    phaseT            phaseNext;
    logic             s1Valid;
    logic             s2Valid;
    logic [WIDTH-1:0] s1Instr;
    logic [WIDTH-1:0] s1Rs;
    logic [WIDTH-1:0] s1Rt;
    logic [WIDTH-1:0] tmp;

    operT             decOper;
    operT             aluOper;
    logic             invA;
    logic             invB;
    logic             cin;
    logic             bSelImm;
    logic [WIDTH-1:0] imm;
    setKindT          setKind;
    logic             twoPhase;
    logic             illegal;

    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic [WIDTH-1:0] aluOut;
    logic             zf;
    logic             sf;
    logic             of;
    logic             cf;
    logic [WIDTH-1:0] s1Result;

    logic             s1Final;
    logic             adv2;
    logic             moveS2;
    logic             accept;
    logic             slbiFirst;

    alu_decode uDecode (
        .instr   (s1Instr),
        .oper    (decOper),
        .invA    (invA),
        .invB    (invB),
        .cin     (cin),
        .bSelImm (bSelImm),
        .imm     (imm),
        .setKind (setKind),
        .twoPhase(twoPhase),
        .illegal (illegal)
    );

    // Second SLBI phase ORs the shifted Rs (held in tmp) with the zero-extended byte.
    always_comb begin
        aluA    = s1Rs;
        aluB    = bSelImm ? imm : s1Rt;
        aluOper = decOper;
        if (twoPhase && phase == P1) begin
            aluA    = tmp;
            aluB    = {8'h00, s1Instr[7:0]};
            aluOper = OP_OR;
        end
    end

    alu uAlu (
        .a     (aluA),
        .b     (aluB),
        .cin   (cin),
        .invA  (invA),
        .invB  (invB),
        .oper  (aluOper),
        .result(aluOut),
        .zf    (zf),
        .sf    (sf),
        .of    (of),
        .cf    (cf)
    );

    always_comb begin
        s1Result = aluOut;
        case (setKind)
            SET_EQ:  s1Result = {15'b0, zf};
            SET_LT:  s1Result = {15'b0, sf ^ of};
            SET_LE:  s1Result = {15'b0, (sf ^ of) | zf};
            SET_CO:  s1Result = {15'b0, cf};
            default: s1Result = aluOut;
        endcase
        if (illegal) begin
            s1Result = '0;
        end
    end

    assign s1Final   = !twoPhase || (phase == P1);
    assign slbiFirst = s1Valid && twoPhase && (phase == P0);
    assign adv2      = !s2Valid || out_ready;
    assign moveS2    = s1Valid && adv2 && s1Final;
    assign in_ready  = rst_n && (!s1Valid || (adv2 && s1Final));
    assign accept    = in_valid && in_ready;
    assign out_valid = s2Valid;

    always_comb begin
        phaseNext = phase;
        if (moveS2) begin
            phaseNext = P0;
        end else if (slbiFirst) begin
            phaseNext = P1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= P0;
        end else begin
            phase <= phaseNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            s1Instr <= '0;
            s1Rs    <= '0;
            s1Rt    <= '0;
            tmp     <= '0;
        end else begin
            if (accept) begin
                s1Valid <= 1'b1;
                s1Instr <= in_instr;
                s1Rs    <= in_rs;
                s1Rt    <= in_rt;
            end else if (moveS2) begin
                s1Valid <= 1'b0;
            end
            if (slbiFirst) begin
                tmp <= aluOut;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid     <= 1'b0;
            out_result  <= '0;
            out_illegal <= 1'b0;
        end else if (moveS2) begin
            s2Valid     <= 1'b1;
            out_result  <= s1Result;
            out_illegal <= illegal;
        end else if (out_ready) begin
            s2Valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed self-checking bench for alu_exec_ctrl: decode/ALU results, set flags, SLBI, stalls and reset.
module tb_alu_exec_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_rs;
    logic [15:0] in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_illegal;

    int          compareCount = 0;
    int          failCount    = 0;
    int          sent;
    int          rcv;
    logic        willAccept;
    logic [15:0] prevResult;
    logic [15:0] expQ [4];

    alu_exec_ctrl #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_illegal(out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] rs, input logic [15:0] rt);
        in_valid = 1'b1;
        in_instr = instr;
        in_rs    = rs;
        in_rt    = rt;
    endtask

    task automatic runOne(input string tag, input logic [15:0] instr, input logic [15:0] rs,
                          input logic [15:0] rt, input logic [15:0] expResult,
                          input logic expIllegal, input int expLat);
        int waitCycles;
        int latency;
        waitCycles = 0;
        applyStimulus(instr, rs, rt);
        while (!in_ready && waitCycles < 8) begin
            tick();
            waitCycles++;
        end
        checkOutput({tag, "_wait"}, 16'(waitCycles), 16'd0);
        tick();
        in_valid = 1'b0;
        latency  = 1;
        while (!out_valid && latency < 8) begin
            tick();
            latency++;
        end
        checkOutput({tag, "_lat"}, 16'(latency), 16'(expLat));
        checkOutput({tag, "_res"}, out_result, expResult);
        checkOutput({tag, "_ill"}, 16'(out_illegal), 16'(expIllegal));
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(16'hD800, 16'h0001, 16'h0001);
        #12;
        checkOutput("rstInReady", 16'(in_ready), 16'd0);
        checkOutput("rstOutValid", 16'(out_valid), 16'd0);
        checkOutput("rstResult", out_result, 16'h0000);
        checkOutput("rstIllegal", 16'(out_illegal), 16'd0);
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("relInReady", 16'(in_ready), 16'd1);

        runOne("sub",   16'hD801, 16'h0003, 16'h0010, 16'h000D, 1'b0, 2);
        runOne("addi",  16'h401F, 16'h0005, 16'h0000, 16'h0004, 1'b0, 2);
        runOne("subi",  16'h4801, 16'h0003, 16'h0000, 16'hFFFE, 1'b0, 2);
        runOne("xori",  16'h501F, 16'hFFFF, 16'h0000, 16'hFFE0, 1'b0, 2);
        runOne("andni", 16'h580F, 16'h00FF, 16'h0000, 16'h00F0, 1'b0, 2);
        runOne("xor",   16'hD802, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 2);
        runOne("andn",  16'hD803, 16'h00FF, 16'h000F, 16'h00F0, 1'b0, 2);
        runOne("rol",   16'hD000, 16'h8001, 16'h0011, 16'h0003, 1'b0, 2);
        runOne("sll",   16'hD001, 16'h0001, 16'h0004, 16'h0010, 1'b0, 2);
        runOne("ror",   16'hD002, 16'h0001, 16'h0001, 16'h8000, 1'b0, 2);
        runOne("roli",  16'hA004, 16'hF001, 16'h0000, 16'h001F, 1'b0, 2);
        runOne("slli",  16'hA803, 16'h0001, 16'h0000, 16'h0008, 1'b0, 2);
        runOne("srli",  16'hB804, 16'h8000, 16'h0000, 16'h0800, 1'b0, 2);
        runOne("btr",   16'hC800, 16'h0001, 16'h0000, 16'h8000, 1'b0, 2);
        runOne("lbi",   16'hC080, 16'h1234, 16'h0000, 16'hFF80, 1'b0, 2);
        runOne("sltOv", 16'hE800, 16'h8000, 16'h0001, 16'h0001, 1'b0, 2);
        runOne("sltNo", 16'hE800, 16'h0001, 16'h8000, 16'h0000, 1'b0, 2);
        runOne("sle",   16'hF000, 16'h1234, 16'h1234, 16'h0001, 1'b0, 2);
        runOne("seq",   16'hE000, 16'h0001, 16'h0002, 16'h0000, 1'b0, 2);
        runOne("sco",   16'hF800, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 2);
        runOne("scoNo", 16'hF800, 16'h0001, 16'h0001, 16'h0000, 1'b0, 2);
        runOne("ill0",  16'h0000, 16'h1111, 16'h2222, 16'h0000, 1'b1, 2);
        runOne("ill13", 16'h9800, 16'h1111, 16'h2222, 16'h0000, 1'b1, 2);
        runOne("slbi",  16'h90CD, 16'h00AB, 16'h0000, 16'hABCD, 1'b0, 3);

        // SLBI followed immediately by an ADD
        applyStimulus(16'h90CD, 16'h00AB, 16'h0000);
        checkOutput("b2bSlbiReady", 16'(in_ready), 16'd1);
        tick();
        applyStimulus(16'hD800, 16'h0001, 16'h0002);
        checkOutput("slbiP0Ready", 16'(in_ready), 16'd0);
        tick();
        checkOutput("slbiP1Ready", 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("b2bSlbiValid", 16'(out_valid), 16'd1);
        checkOutput("b2bSlbiRes", out_result, 16'hABCD);
        tick();
        checkOutput("b2bAddValid", 16'(out_valid), 16'd1);
        checkOutput("b2bAddRes", out_result, 16'h0003);
        tick();
        checkOutput("b2bDrained", 16'(out_valid), 16'd0);

        // Four ADDs with writeback stalled for three cycles
        for (int k = 0; k < 4; k++) begin
            expQ[k] = 16'h0100 + 16'(k);
        end
        sent = 0;
        rcv  = 0;
        applyStimulus(16'hD800, 16'h0000, 16'h0100);
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            #0;
            if (c == 2) begin
                checkOutput("strmInReady", 16'(in_ready), 16'd0);
                checkOutput("strmHeadValid", 16'(out_valid), 16'd1);
            end
            if (c == 3 || c == 4) begin
                checkOutput("strmHold", out_result, prevResult);
                checkOutput("strmHoldValid", 16'(out_valid), 16'd1);
            end
            prevResult = out_result;
            if (out_valid && out_ready) begin
                if (rcv < 4) begin
                    checkOutput($sformatf("strmRes%0d", rcv), out_result, expQ[rcv]);
                end
                rcv++;
            end
            willAccept = in_valid && in_ready;
            tick();
            if (willAccept) begin
                sent++;
                if (sent < 4) begin
                    applyStimulus(16'hD800, 16'(sent), 16'h0100);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checkOutput("strmSent", 16'(sent), 16'd4);
        checkOutput("strmRcv", 16'(rcv), 16'd4);

        // Reset while S2 is stalled and SLBI sits in its second phase
        out_ready = 1'b0;
        applyStimulus(16'hD800, 16'h0001, 16'h0001);
        tick();
        applyStimulus(16'h90CD, 16'h00AB, 16'h0000);
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("preRstValid", 16'(out_valid), 16'd1);
        checkOutput("preRstRes", out_result, 16'h0002);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", 16'(out_valid), 16'd0);
        checkOutput("midRstRes", out_result, 16'h0000);
        checkOutput("midRstReady", 16'(in_ready), 16'd0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("lostInstr", 16'(out_valid), 16'd0);
        runOne("slbiAfterRst", 16'h9034, 16'h0012, 16'h0000, 16'h1234, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
